bcd2bin_seq: RTL and testbench

- Parametrised, handshaked BCD-to-binary converter for DIGITS packed BCD digits.
- Converts iteratively, most significant digit first, one digit per clock: acc = acc*10 + digit.
- Sits between the keypad/switch BCD entry logic and the binary arithmetic datapath.
- Replaces single-cycle two-digit conversion wherever more digits, or a registered result with flow control, are required.

---
 rtl/bcd2bin_seq_if.sv | 38 +++
 rtl/bcd2bin_seq.sv | 107 ++++++++++
 tb/tb_bcd2bin_seq.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd2bin_seq_if.sv
// ---------------------------------------------------------------------------
// bcd2bin_seq_if
//   Handshake bundle for the sequential BCD-to-binary converter.
//   master : the side that supplies BCD words and consumes results
//   slave  : the converter itself
// Signals:
//   in_valid  - bcd_in holds a word to convert
//   in_ready  - converter can accept a word
//   bcd_in    - 4*DIGITS packed BCD, digit DIGITS-1 in the top nibble
//   out_valid - bin_out/err hold a finished result
//   out_ready - consumer takes the result
//   bin_out   - OUT_W-bit binary result
//   err       - accepted word contained a nibble > 9 (check build only)
//   busy      - conversion in progress
// ---------------------------------------------------------------------------
interface bcd2bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      bin_out;
  logic                  err;
  logic                  busy;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err, busy
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err, busy
  );
endinterface

// File: rtl/bcd2bin_seq.sv
// ---------------------------------------------------------------------------
// bcd2bin_seq
//   Iterative BCD-to-binary converter. Accepts a DIGITS-digit packed BCD word,
//   folds in one digit per clock (most significant first) as acc*10 + digit,
//   and presents a registered result with valid/ready flow control.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - bcd2bin_seq_if.slave (in_valid/in_ready/bcd_in,
//           out_valid/out_ready/bin_out/err, busy)
// Optional feature:
//   BCD2BIN_SEQ_ERR_CHECK_EN - when defined, err flags any nibble > 9 in the
//   accepted word (sticky for that word). When undefined, err is tied low.
//   bin_out is identical in both builds: invalid nibbles use their raw value.
// ---------------------------------------------------------------------------
module bcd2bin_seq #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  bcd2bin_seq_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int               CNT_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  logic [1:0]          r_state;
  logic [4*DIGITS-1:0] r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic [OUT_W-1:0]    r_acc;
  logic [OUT_W-1:0]    r_bin;

  logic [3:0]          w_top;
  logic [OUT_W-1:0]    w_acc_next;

  assign w_top = r_shift[4*DIGITS-1 -: 4];

  // acc*10 as (acc<<3)+(acc<<1); every term is cut to OUT_W so an undersized
  // output simply wraps modulo 2^OUT_W.
  assign w_acc_next = OUT_W'({r_acc, 3'b000}) + OUT_W'({r_acc, 1'b0})
                    + OUT_W'(w_top);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_bin   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_shift <= bus.bcd_in;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_acc   <= w_acc_next;
          r_shift <= r_shift << 4;
          r_cnt   <= r_cnt + 1'b1;
          // bin_out is only refreshed when a conversion completes, so the
          // previous result stays visible while the next word is in flight.
          if (r_cnt == LAST_CNT) begin
            r_bin   <= w_acc_next;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BCD2BIN_SEQ_ERR_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && bus.in_valid) begin
      r_err <= 1'b0;
    end else if (r_state == S_CONV && w_top > 4'd9) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state == S_CONV);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.bin_out   = r_bin;

endmodule

// File: tb/tb_bcd2bin_seq.sv
module tb_bcd2bin_seq;

`ifdef BCD2BIN_SEQ_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   n_xfer;
  int   n_exp;

  bcd2bin_seq_if #(.DIGITS(4), .OUT_W(14)) bus  ();
  bcd2bin_seq_if #(.DIGITS(1), .OUT_W(4))  bus1 ();

  bcd2bin_seq #(.DIGITS(4), .OUT_W(14)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  bcd2bin_seq #(.DIGITS(1), .OUT_W(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] bin;
    logic        err;
  } exp_t;

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] bin;
    logic        err;
  } vec_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Independent reference: decimal weighting of raw nibble values.
  function automatic exp_t model(input logic [15:0] w);
    exp_t e;
    int   acc;
    acc   = 0;
    e.err = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      acc = acc * 10 + int'(w[4*i +: 4]);
      if (w[4*i +: 4] > 4'd9) e.err = ERR_EN;
    end
    e.bin = 14'(acc % 16384);
    return e;
  endfunction

  // Scoreboard: push on accept, pop and compare on result transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) sb_q.push_back(model(bus.bcd_in));
      if (bus.out_valid && bus.out_ready) begin
        n_xfer++;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_xfer", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_bin", 32'(bus.bin_out), 32'(e.bin));
          check("sb_err", 32'(bus.err), 32'(e.err));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check("send_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.bcd_in   = w;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    total = 0; bad = 0; n_xfer = 0; n_exp = 0;
    vecs[0] = '{16'h1234, 14'd1234, 1'b0};
    vecs[1] = '{16'h9999, 14'd9999, 1'b0};
    vecs[2] = '{16'h0000, 14'd0,    1'b0};
    vecs[3] = '{16'h0042, 14'd42,   1'b0};
    vecs[4] = '{16'h12A4, 14'd1304, ERR_EN};
    vecs[5] = '{16'h0999, 14'd999,  1'b0};
    vecs[6] = '{16'h0001, 14'd1,    1'b0};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;  bus.bcd_in = '0;  bus.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.bcd_in = '0; bus1.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_bin",       32'(bus.bin_out),   32'd0);
    check("rst_err",       32'(bus.err),       32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    rst_n = 1'b1;
    tick();

    // Latency of a single word with the consumer always ready.
    bus.out_ready = 1'b1;
    send(16'h1234);
    n_exp++;
    check("t1_busy", 32'(bus.busy), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("t1_out_valid", 32'(bus.out_valid), (i == 4) ? 32'd1 : 32'd0);
    end
    check("t1_bin",      32'(bus.bin_out),  32'd1234);
    check("t1_err",      32'(bus.err),      32'd0);
    check("t1_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("t1_ready_back", 32'(bus.in_ready),  32'd1);
    check("t1_released",   32'(bus.out_valid), 32'd0);

    // Table of words, back to back.
    for (int v = 0; v < 7; v++) begin
      send(vecs[v].bcd);
      n_exp++;
      wait_out();
      check("tbl_bin", 32'(bus.bin_out), 32'(vecs[v].bin));
      check("tbl_err", 32'(bus.err),     32'(vecs[v].err));
    end
    tick();

    // out_ready without out_valid has no effect.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_no_valid", 32'(bus.out_valid), 32'd0);
      check("idle_bin_hold", 32'(bus.bin_out),   32'd1);
    end

    // Backpressure with an ignored word during the stall.
    bus.out_ready = 1'b0;
    send(16'h0042);
    n_exp++;
    check("bp_prev_bin_hold", 32'(bus.bin_out), 32'd1);
    wait_out();
    bus.bcd_in = 16'h7777;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = (i == 2);
      tick();
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_bin",   32'(bus.bin_out),   32'd42);
      check("bp_ready", 32'(bus.in_ready),  32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_idle", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;

    // in_valid and out_ready together in DONE.
    send(16'h0321);
    n_exp++;
    wait_out();
    bus.bcd_in    = 16'h0654;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check("dual_released", 32'(bus.out_valid), 32'd0);
    check("dual_not_busy", 32'(bus.busy),      32'd0);
    check("dual_bin_321",  32'(bus.bin_out),   32'd321);
    tick();
    bus.in_valid = 1'b0;
    n_exp++;
    check("dual_accepted", 32'(bus.busy), 32'd1);
    wait_out();
    check("dual_bin_654", 32'(bus.bin_out), 32'd654);
    tick();

    // Asynchronous reset mid-conversion.
    send(16'h5678);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("ar_out_valid", 32'(bus.out_valid), 32'd0);
    check("ar_bin",       32'(bus.bin_out),   32'd0);
    check("ar_busy",      32'(bus.busy),      32'd0);
    check("ar_in_ready",  32'(bus.in_ready),  32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    send(16'h0001);
    n_exp++;
    wait_out();
    check("ar_next_bin", 32'(bus.bin_out), 32'd1);
    tick();

    // Single-digit instance.
    bus1.bcd_in   = 4'h7;
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    check("d1_busy",  32'(bus1.busy),      32'd1);
    check("d1_wait",  32'(bus1.out_valid), 32'd0);
    tick();
    check("d1_valid", 32'(bus1.out_valid), 32'd1);
    check("d1_bin7",  32'(bus1.bin_out),   32'd7);
    tick();
    bus1.bcd_in   = 4'hB;
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    tick();
    check("d1_binB", 32'(bus1.bin_out), 32'd11);
    check("d1_errB", 32'(bus1.err),     32'(ERR_EN));
    tick();

    check("sb_empty",  32'(sb_q.size()), 32'd0);
    check("sb_xfers",  32'(n_xfer),      32'(n_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
